ramp_arbiter: RTL and testbench
===============================

# ramp_arbiter

Round-robin controller that shares a single saturating ramp counter among `N_REQ` requesters. The winning requester owns the counter, which runs 0 → MAX. The block pulses `done` and releases the grant. It is the sequencing and sharing layer that sits above the bare saturating-counter datapath in the same design.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, ≥2.
- `CNT_W`, default 2: ramp counter width; MAX = 2^CNT_W − 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset. 0 resets immediately, independent of `clk`.
- `req`  in  N_REQ  level requests, one bit per requester.
- `gnt`  out  N_REQ  one-hot grant, registered. All-zero when idle.
- `busy`  out  1  high whenever state ≠ IDLE.
- `cnt`  out  CNT_W  current ramp value, registered.
- `sat`  out  1  high when `cnt` == MAX and state = RUN.
- `done`  out  1  one-cycle pulse marking successful ramp completion.
- `gnt_id`  out  clog2(N_REQ)  binary index of the current or last owner.

## Operation
- **Reset values:** `gnt`=0, `busy`=0, `cnt`=0, `sat`=0, `done`=0, `gnt_id`=0, state=IDLE, `last`=N_REQ−1, so requester 0 has first priority.
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - If `req`≠0, pick the first set bit searching upward from `last`+1 with wrap-around.
  - Register `gnt` one-hot and `gnt_id`, set `cnt`=0, go to RUN.
  - If `req`=0, stay in IDLE with all outputs at reset values (`gnt_id` holds).
- **RUN:**
  - Each cycle, if `req[gnt_id]`=1 and `cnt`<MAX, increment `cnt`.
  - If `cnt`==MAX and `req[gnt_id]`=1, go to DONE with `done`=1 and `cnt` held at MAX.
  - **Abort:** if `req[gnt_id]`=0 in any RUN cycle, go to IDLE. Clear `gnt` and `cnt`, no `done`, and set `last`=`gnt_id`.
- **DONE:** `gnt` is still asserted and `done`=1. Next cycle go to IDLE, clear `gnt` and `cnt`, and set `last`=`gnt_id`.
- **Arbitration scope:** arbitration happens only in IDLE. Requests arriving during RUN or DONE wait; nothing is queued beyond the `req` level.
- **Counter width:** `cnt` never wraps. The increment is guarded by `cnt`<MAX, and arithmetic is CNT_W bits unsigned.
- **Reset during RUN or DONE:** immediate return to reset values. No `done` is issued and the pointer returns to N_REQ−1.

## Timing
- **Grant latency:** `req` sampled high in IDLE at edge k gives `gnt` visible after edge k, i.e. 1 cycle.
- **Ramp sequence:** with `gnt` cycle g (`cnt`=0), `cnt`=1,2,…,MAX at g+1…g+MAX. `sat`=1 at g+MAX.
- **Completion:** `done`=1 at g+MAX+1. `gnt`=0 and `busy`=0 at g+MAX+2.
- **Back-to-back:** the earliest next grant is at g+MAX+3, i.e. one IDLE cycle. With CNT_W=2 the grant period is 6 cycles.
- **Abort timing:** `req[gnt_id]` low sampled at edge e gives `gnt`=0 and `cnt`=0 after edge e.
- **Output stability:** all outputs are registered, with no combinational path from `req` to any output.

## Structure
- Package `ramp_arb_pkg`: state enum (IDLE, RUN, DONE) and a `cnt_max(CNT_W)` constant function.
- Sub-module `ramp_rr_pick`, purely combinational.
  - Inputs: `req` and `last`.
  - Outputs: one-hot `pick`, binary `pick_id` and `any`.
  - Implemented as a double-width rotate-and-priority scheme.
- Top: state register, counter, `last` pointer, and output registers.

## Test plan
- **Reset:** assert `reset`=0 mid-RUN at `cnt`=2 → all outputs 0 immediately. After release with `req`=4'b1111, `gnt`=4'b0001.
- **Single requester:** `req`=4'b0100 held → `gnt`=4'b0100 and `cnt` 0,1,2,3, then `sat`=1, `done`=1 at grant+4, `gnt`=0 at grant+5.
- **Fairness:** `req`=4'b1111 held for 24 cycles → grants in order 0,1,2,3, each with `done`. Exactly 4 `done` pulses and a 6-cycle period.
- **Abort:** `req`=4'b0010 granted, drop `req[1]` at `cnt`=1 → `gnt`=0 and `cnt`=0 next cycle, no `done`. With `req`=4'b0011, the next grant is requester 0, because `last`=1 wraps the search to 2,3,0.
- **Late request:** `req[3]` rises during requester 0's RUN → it is not granted until IDLE. `gnt`=4'b1000 appears 1 cycle after requester 0's `gnt` falls.
- **Saturation hold:** hold `req` through DONE → `cnt` stays 3 for two cycles and never wraps to 0 while `gnt`≠0.

Source files
------------

// File: rtl/ramp_arb_pkg.sv
// Shared types and helpers for the round-robin ramp arbiter.
// Holds the controller state encoding and the counter saturation value.
package ramp_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_max(input int w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/ramp_rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`, with wrap.
// Zero latency. No backpressure: the result is a pure function of req and last.
module ramp_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   last,
   output logic [N_REQ-1:0] pick,
   output logic [IDW-1:0]   pick_id,
   output logic             any
);

   int                  start;
   int                  hit;
   logic                found;
   logic [N_REQ-1:0]    lo;
   logic [2*N_REQ-1:0]  dbl;

   // Lower copy keeps only requests at or above the start point; the upper copy
   // supplies the wrapped-around candidates, so the first set bit is the winner.
   always_comb begin
      start = (int'(last) >= N_REQ - 1) ? 0 : int'(last) + 1;
      for (int i = 0; i < N_REQ; i++) begin
         lo[i] = req[i] && (i >= start);
      end
      dbl   = {req, lo};
      hit   = 0;
      found = 1'b0;
      for (int j = 0; j < 2 * N_REQ; j++) begin
         if (dbl[j] && !found) begin
            hit   = j;
            found = 1'b1;
         end
      end
      if (hit >= N_REQ) begin
         hit = hit - N_REQ;
      end
      any     = |req;
      pick_id = any ? IDW'(hit) : '0;
      for (int i = 0; i < N_REQ; i++) begin
         pick[i] = any && (hit == i);
      end
   end

endmodule

// File: rtl/ramp_arbiter.sv
// Round-robin owner of a shared saturating ramp counter; grant 1 cycle after request,
// ramp 0..MAX, one-cycle done, then one IDLE cycle before the next grant.
module ramp_arbiter
   import ramp_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int CNT_W = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   output logic [N_REQ-1:0]         gnt,
   output logic                     busy,
   output logic [CNT_W-1:0]         cnt,
   output logic                     sat,
   output logic                     done,
   output logic [$clog2(N_REQ)-1:0] gnt_id
);

   localparam int                IDW      = $clog2(N_REQ);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(cnt_max(CNT_W));
   localparam logic [IDW-1:0]    LAST_RST = IDW'(N_REQ - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDW-1:0]     last_q, last_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0]     gnt_id_q, gnt_id_d;
   logic               sat_q, sat_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic [N_REQ-1:0]   pick;
   logic [IDW-1:0]     pick_id;
   logic               pick_any;
   logic               own_req;

   ramp_rr_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_pick (
      .req     (req),
      .last    (last_q),
      .pick    (pick),
      .pick_id (pick_id),
      .any     (pick_any)
   );

   // gnt_q is one-hot, so masking req with it selects the owner's request bit.
   assign own_req = |(req & gnt_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      sat_d    = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            gnt_d = '0;
            if (pick_any) begin
               gnt_d    = pick;
               gnt_id_d = pick_id;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (!own_req) begin
               state_d = IDLE;
               gnt_d   = '0;
               cnt_d   = '0;
               last_d  = gnt_id_q;
            end else if (cnt_q < CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
               sat_d = (cnt_d == CNT_MAX);
            end else begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
            last_d  = gnt_id_q;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_q   <= LAST_RST;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         sat_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         sat_q    <= sat_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign gnt    = gnt_q;
   assign busy   = busy_q;
   assign cnt    = cnt_q;
   assign sat    = sat_q;
   assign done   = done_q;
   assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_ramp_arbiter.sv
// Directed bench for ramp_arbiter (N_REQ=4, CNT_W=2); outputs sampled on the falling edge.
module tb_ramp_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       busy;
   logic [1:0] cnt;
   logic       sat;
   logic       done;
   logic [1:0] gnt_id;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ramp_arbiter #(
      .N_REQ (4),
      .CNT_W (2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .gnt    (gnt),
      .busy   (busy),
      .cnt    (cnt),
      .sat    (sat),
      .done   (done),
      .gnt_id (gnt_id)
   );

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   // With req low a RUN aborts and a DONE retires in one edge; two edges always reach IDLE.
   task automatic drain;
      req = 4'b0000;
      step;
      step;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      req   = 4'b0000;
      @(negedge clk);
      n_tests++;
      if ({gnt, busy, cnt, sat, done, gnt_id} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_values: got %b want 0", {gnt, busy, cnt, sat, done, gnt_id});
      end
      reset = 1'b1;
      req   = 4'b0100;
      step;
      n_tests++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
         n_fail++;
         $display("FAIL reset_first_gnt: gnt=%b id=%0d want 0100 id=2", gnt, gnt_id);
      end
      step;
      step;
      n_tests++;
      if (cnt !== 2'd2 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre_cnt: cnt=%0d busy=%b want 2 1", cnt, busy);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if ({gnt, busy, cnt, sat, done, gnt_id} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_midrun_async: got %b want 0", {gnt, busy, cnt, sat, done, gnt_id});
      end
      req = 4'b1111;
      @(negedge clk);
      reset = 1'b1;
      step;
      n_tests++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_release_gnt: gnt=%b id=%0d want 0001 id=0", gnt, gnt_id);
      end
      drain;
   endtask

   task automatic test_fairness;
      int         grants;
      int         dones;
      int         ids[4];
      int         gcyc[4];
      logic [3:0] prev;
      grants = 0;
      dones  = 0;
      prev   = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         ids[k]  = -1;
         gcyc[k] = -100;
      end
      reset = 1'b0;
      req   = 4'b1111;
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 24; c++) begin
         step;
         if (gnt !== 4'b0000 && prev === 4'b0000) begin
            if (grants < 4) begin
               ids[grants]  = int'(gnt_id);
               gcyc[grants] = c;
            end
            grants++;
         end
         if (done === 1'b1) dones++;
         prev = gnt;
      end
      n_tests++;
      if (grants != 4) begin
         n_fail++;
         $display("FAIL fair_grant_count: got %0d want 4", grants);
      end
      n_tests++;
      if (dones != 4) begin
         n_fail++;
         $display("FAIL fair_done_count: got %0d want 4", dones);
      end
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (ids[k] != k) begin
            n_fail++;
            $display("FAIL fair_order[%0d]: got %0d want %0d", k, ids[k], k);
         end
      end
      for (int k = 1; k < 4; k++) begin
         n_tests++;
         if (gcyc[k] - gcyc[k-1] != 6) begin
            n_fail++;
            $display("FAIL fair_period[%0d]: got %0d want 6", k, gcyc[k] - gcyc[k-1]);
         end
      end
      drain;
   endtask

   task automatic test_single;
      req = 4'b0100;
      step;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (gnt !== 4'b0100 || cnt !== 2'(k) || sat !== (k == 3) || done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ramp[%0d]: gnt=%b cnt=%0d sat=%b done=%b want 0100 %0d %b 0",
                     k, gnt, cnt, sat, done, k, (k == 3));
         end
         step;
      end
      n_tests++;
      if (done !== 1'b1 || gnt !== 4'b0100 || cnt !== 2'd3 || sat !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: done=%b gnt=%b cnt=%0d sat=%b want 1 0100 3 0", done, gnt, cnt, sat);
      end
      step;
      n_tests++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || cnt !== 2'd0 || done !== 1'b0 || gnt_id !== 2'd2) begin
         n_fail++;
         $display("FAIL single_release: gnt=%b busy=%b cnt=%0d done=%b id=%0d want 0000 0 0 0 2",
                  gnt, busy, cnt, done, gnt_id);
      end
      drain;
   endtask

   task automatic test_abort;
      req = 4'b0010;
      step;
      n_tests++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1 || cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL abort_gnt: gnt=%b id=%0d cnt=%0d want 0010 1 0", gnt, gnt_id, cnt);
      end
      step;
      n_tests++;
      if (cnt !== 2'd1) begin
         n_fail++;
         $display("FAIL abort_cnt1: got %0d want 1", cnt);
      end
      req = 4'b0000;
      step;
      n_tests++;
      if (gnt !== 4'b0000 || cnt !== 2'd0 || done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_clear: gnt=%b cnt=%0d done=%b busy=%b want 0000 0 0 0", gnt, cnt, done, busy);
      end
      req = 4'b0011;
      step;
      n_tests++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
         n_fail++;
         $display("FAIL abort_next_gnt: gnt=%b id=%0d want 0001 0", gnt, gnt_id);
      end
      drain;
   endtask

   task automatic test_late;
      req = 4'b0001;
      step;
      n_tests++;
      if (gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL late_gnt0: got %b want 0001", gnt);
      end
      step;
      req = 4'b1001;
      step;
      n_tests++;
      if (gnt !== 4'b0001 || cnt !== 2'd2) begin
         n_fail++;
         $display("FAIL late_no_preempt: gnt=%b cnt=%0d want 0001 2", gnt, cnt);
      end
      step;
      step;
      n_tests++;
      if (done !== 1'b1 || gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL late_done0: done=%b gnt=%b want 1 0001", done, gnt);
      end
      step;
      n_tests++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL late_idle: gnt=%b busy=%b want 0000 0", gnt, busy);
      end
      step;
      n_tests++;
      if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
         n_fail++;
         $display("FAIL late_gnt3: gnt=%b id=%0d want 1000 3", gnt, gnt_id);
      end
      drain;
   endtask

   task automatic test_sat_hold;
      int   exp_cnt[6];
      logic exp_gnt[6];
      logic exp_done[6];
      exp_cnt  = '{0, 1, 2, 3, 3, 0};
      exp_gnt  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      req = 4'b0001;
      for (int c = 0; c < 6; c++) begin
         step;
         n_tests++;
         if (cnt !== 2'(exp_cnt[c]) || (gnt !== 4'b0000) !== exp_gnt[c] || done !== exp_done[c]) begin
            n_fail++;
            $display("FAIL sat_hold[%0d]: cnt=%0d gnt=%b done=%b want cnt=%0d gnt_on=%b done=%b",
                     c, cnt, gnt, done, exp_cnt[c], exp_gnt[c], exp_done[c]);
         end
      end
      drain;
   endtask

   initial begin
      reset = 1'b0;
      req   = 4'b0000;
      test_reset;
      test_fairness;
      test_single;
      test_abort;
      test_late;
      test_sat_hold;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
